// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader
//   Drives the three PWM enables of the iCE40 SB_RGBA_DRV LED macro. A target
//   colour and fade rate are accepted over a valid/ready handshake. Each channel
//   then ramps one LSB per fade tick towards its target. The duty used by the PWM
//   comparator is only reloaded at the end of a PWM period, so no pulse is ever
//   cut short or stretched.
//
// Ports
//   clki                        module clock, rising edge
//   rst                         synchronous active-high reset
//   cfg_valid / cfg_ready       request handshake
//   cfg_red/green/blue          target duty per channel (PWM_BITS)
//   cfg_div                     fade tick period minus one, in clki cycles
//   pwm_red/green/blue          to RGB2PWM / RGB1PWM / RGB0PWM
//   busy                        fade in progress
//   done                        one-cycle pulse when a fade completes
module rgb_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int DIV_BITS = 16
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PWM_BITS-1:0] cfg_red,
  input  logic [PWM_BITS-1:0] cfg_green,
  input  logic [PWM_BITS-1:0] cfg_blue,
  input  logic [DIV_BITS-1:0] cfg_div,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue,
  output logic                busy,
  output logic                done
);

  typedef enum logic {IDLE, FADING} state_t;

  // Channel index: 0 = red, 1 = green, 2 = blue.
  state_t              state, state_nxt;
  logic [PWM_BITS-1:0] cnt_p0;
  logic [DIV_BITS-1:0] presc_p0;
  logic [DIV_BITS-1:0] div_p0;
  logic [PWM_BITS-1:0] cfg_col [3];
  logic [PWM_BITS-1:0] cur_p0 [3];
  logic [PWM_BITS-1:0] tgt_p0 [3];
  logic [PWM_BITS-1:0] shadow_p0 [3];
  logic [2:0]          pwm_p1;
  logic                accept;
  logic                all_eq;
  logic                tick;

  // One saturating step towards the target; never overshoots or wraps.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] c,
                                                      input logic [PWM_BITS-1:0] t);
    if (c < t)      return c + 1'b1;
    else if (c > t) return c - 1'b1;
    else            return c;
  endfunction

  assign cfg_col[0] = cfg_red;
  assign cfg_col[1] = cfg_green;
  assign cfg_col[2] = cfg_blue;

  assign accept = cfg_valid && cfg_ready;
  assign all_eq = (cur_p0[0] == tgt_p0[0]) && (cur_p0[1] == tgt_p0[1]) &&
                  (cur_p0[2] == tgt_p0[2]);
  // Completion is checked before stepping, so no tick is issued once settled.
  assign tick   = (state == FADING) && !all_eq && (presc_p0 == div_p0);

  // FSM state register
  always_ff @(posedge clki) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = FADING;
      FADING:  if (all_eq)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state == FADING);
  end

  // Completion pulse, coincident with cfg_ready returning high
  always_ff @(posedge clki) begin
    if (rst) done <= 1'b0;
    else     done <= (state == FADING) && all_eq;
  end

  // Stage p0: PWM counter, fade prescaler, request latch and duty ramp
  always_ff @(posedge clki) begin
    if (rst) begin
      cnt_p0   <= '0;
      presc_p0 <= '0;
      div_p0   <= '0;
      for (int i = 0; i < 3; i++) begin
        cur_p0[i]    <= '0;
        tgt_p0[i]    <= '0;
        shadow_p0[i] <= '0;
      end
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;

      if (accept) begin
        div_p0   <= cfg_div;
        presc_p0 <= '0;
        for (int i = 0; i < 3; i++) tgt_p0[i] <= cfg_col[i];
      end else if ((state == FADING) && !all_eq) begin
        presc_p0 <= (presc_p0 == div_p0) ? '0 : presc_p0 + 1'b1;
      end

      if (tick) begin
        for (int i = 0; i < 3; i++) cur_p0[i] <= step_toward(cur_p0[i], tgt_p0[i]);
      end

      // Reload on the last count of a period so the new duty starts at cnt == 0.
      if (&cnt_p0) begin
        for (int i = 0; i < 3; i++) shadow_p0[i] <= cur_p0[i];
      end
    end
  end

  // Stage p1: registered PWM compare
  always_ff @(posedge clki) begin
    if (rst) begin
      pwm_p1 <= '0;
    end else begin
      for (int i = 0; i < 3; i++) pwm_p1[i] <= (cnt_p0 < shadow_p0[i]);
    end
  end

  assign pwm_red   = pwm_p1[0];
  assign pwm_green = pwm_p1[1];
  assign pwm_blue  = pwm_p1[2];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Testbench for rgb_pwm_fader: randomized and directed fade requests, with a
// timeline model of each channel's duty and a scoreboard of done pulses.
module tb_rgb_pwm_fader;

  localparam int PB  = 8;
  localparam int DB  = 16;
  localparam int PER = 1 << PB;
  localparam int TMO = 5000;

  logic          clki = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [PB-1:0] cfg_red = '0;
  logic [PB-1:0] cfg_green = '0;
  logic [PB-1:0] cfg_blue = '0;
  logic [DB-1:0] cfg_div = '0;
  logic          pwm_red, pwm_green, pwm_blue;
  logic          busy, done;

  always #5 clki = ~clki;

  rgb_pwm_fader #(.PWM_BITS(PB), .DIV_BITS(DB)) dut (
    .clki(clki), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_red(cfg_red), .cfg_green(cfg_green), .cfg_blue(cfg_blue),
    .cfg_div(cfg_div), .pwm_red(pwm_red), .pwm_green(pwm_green),
    .pwm_blue(pwm_blue), .busy(busy), .done(done)
  );

  // Timeline of events: a reset zeroes every channel; a fade starting at edge
  // e moves each channel floor((n-e)/(div+1)) steps by edge n, capped at target.
  typedef struct packed {
    int             edge_n;
    bit             is_reset;
    logic [2:0][7:0] st;
    logic [2:0][7:0] tg;
    int             dv;
  } rec_t;

  rec_t hist[$];
  int   exp_done_q[$];
  int   ecnt = 0;
  int   er = 0;
  int   busy_until = 0;
  int   acc_count = 0;
  int   checks = 0;
  int   fails = 0;
  bit   armed = 1'b0;
  int   acc [3];

  function automatic int model_cur(int ch, int n);
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].edge_n <= n) begin
        int s, t, steps, d;
        if (hist[i].is_reset) return 0;
        s     = int'(hist[i].st[ch]);
        t     = int'(hist[i].tg[ch]);
        steps = (n - hist[i].edge_n) / (hist[i].dv + 1);
        d     = t - s;
        if (d >= 0) return s + ((steps < d) ? steps : d);
        else        return s - ((steps < -d) ? steps : -d);
      end
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, ecnt);
    end
  endtask

  // Model update at each edge, then sampled comparison 1 time unit later.
  always @(posedge clki) begin : mon
    bit   r_s, v_s, exp_d;
    int   tg [3];
    int   dv, m, dd, dlt;
    rec_t rec;
    int   pw [3];
    string nm [3];
    nm[0] = "duty_red"; nm[1] = "duty_green"; nm[2] = "duty_blue";
    r_s = rst; v_s = cfg_valid;
    tg[0] = int'(cfg_red); tg[1] = int'(cfg_green); tg[2] = int'(cfg_blue);
    dv = int'(cfg_div);
    ecnt++;
    if (r_s) begin
      armed = 1'b1;
      er = ecnt;
      busy_until = 0;
      exp_done_q.delete();
      rec = '0;
      rec.edge_n = ecnt;
      rec.is_reset = 1'b1;
      hist.push_back(rec);
      for (int c = 0; c < 3; c++) acc[c] = 0;
    end else if (armed && v_s && (ecnt - 1 >= busy_until)) begin
      rec = '0;
      rec.edge_n = ecnt;
      rec.dv = dv;
      m = 0;
      for (int c = 0; c < 3; c++) begin
        rec.st[c] = 8'(model_cur(c, ecnt - 1));
        rec.tg[c] = 8'(tg[c]);
        dlt = tg[c] - int'(rec.st[c]);
        if (dlt < 0) dlt = -dlt;
        if (dlt > m) m = dlt;
      end
      dd = ecnt + (dv + 1) * m + 1;
      exp_done_q.push_back(dd);
      busy_until = dd;
      hist.push_back(rec);
      acc_count++;
    end
    #1;
    if (armed) begin
      chk("cfg_ready", int'(cfg_ready), int'(ecnt >= busy_until));
      chk("busy", int'(busy), int'(ecnt < busy_until));
      exp_d = (exp_done_q.size() > 0) && (exp_done_q[0] == ecnt);
      chk("done", int'(done), int'(exp_d));
      if (exp_d) void'(exp_done_q.pop_front());
      pw[0] = int'(pwm_red); pw[1] = int'(pwm_green); pw[2] = int'(pwm_blue);
      if (r_s) begin
        chk("pwm_after_reset", pw[0] + pw[1] + pw[2], 0);
      end else begin
        for (int c = 0; c < 3; c++) acc[c] += pw[c];
        // Samples after edges P+1..P+256 show the period starting at edge P,
        // whose duty was captured from cur in the cycle after edge P-1.
        if ((ecnt - er) % PER == 0) begin
          if (ecnt - PER - 1 >= er) begin
            for (int c = 0; c < 3; c++) chk(nm[c], acc[c], model_cur(c, ecnt - PER - 1));
          end
          for (int c = 0; c < 3; c++) acc[c] = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clki);
  endtask

  task automatic send(input int r, input int g, input int b, input int d);
    int start_acc, waited;
    @(negedge clki);
    cfg_valid = 1'b1;
    cfg_red   = PB'(r);
    cfg_green = PB'(g);
    cfg_blue  = PB'(b);
    cfg_div   = DB'(d);
    start_acc = acc_count;
    waited    = 0;
    while (acc_count == start_acc && waited < TMO) begin
      @(negedge clki);
      waited++;
    end
    chk("accept_in_time", int'(waited < TMO), 1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (ecnt < busy_until && waited < TMO) begin
      @(negedge clki);
      waited++;
    end
    chk("fade_in_time", int'(waited < TMO), 1);
  endtask

  initial begin
    int r, g, b, d;
    for (int c = 0; c < 3; c++) acc[c] = 0;
    // Reset, then quiescent outputs
    repeat (3) @(negedge clki);
    rst = 1'b0;
    idle(512);

    // Full ramp from zero at one step per cycle
    send(255, 128, 0, 0);
    wait_idle();
    idle(3 * PER);

    // Green fades down with a slower tick
    send(255, 0, 0, 3);
    wait_idle();
    idle(2 * PER);

    // Second request held on cfg_valid during a fade
    send(10, 20, 30, 1);
    send(40, 50, 60, 0);
    wait_idle();
    idle(300);

    // No-op request
    send(40, 50, 60, 2);
    wait_idle();
    idle(10);

    // Reset in the middle of a fade
    send(100, 0, 0, 0);
    wait_idle();
    send(200, 0, 0, 5);
    idle(50 * 6);
    rst = 1'b1;
    @(negedge clki);
    rst = 1'b0;
    idle(2 * PER + 10);

    // Random requests, sometimes queued behind a running fade
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      d = $urandom_range(0, 3);
      send(r, g, b, d);
      if ($urandom_range(0, 1) == 1) wait_idle();
      idle($urandom_range(0, 300));
    end
    wait_idle();
    idle(2 * PER + 10);

    chk("pending_done", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
Generates the three PWM enable signals that feed the iCE40 SB_RGBA_DRV LED driver hard macro on Fomu: blue to RGB0PWM, green to RGB1PWM, red to RGB2PWM. Control logic sends an RGB target colour and a fade rate through a valid/ready handshake. Each channel's duty ramps linearly, one LSB per fade tick, from its current value to the target. Duty changes take effect only on PWM period boundaries, so the LEDs never see a glitched pulse.

Parameters:
PWM_BITS, 8, width of the PWM counter and of each duty/target value; period is 2**PWM_BITS cycles
DIV_BITS, 16, width of the fade prescaler and of cfg_div

Ports:
clki  input  1  module clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  new fade request present
cfg_ready  output  1  fader can accept a request
cfg_red  input  PWM_BITS  target red duty
cfg_green  input  PWM_BITS  target green duty
cfg_blue  input  PWM_BITS  target blue duty
cfg_div  input  DIV_BITS  fade tick period minus one, in clki cycles
pwm_red  output  1  to SB_RGBA_DRV RGB2PWM
pwm_green  output  1  to SB_RGBA_DRV RGB1PWM
pwm_blue  output  1  to SB_RGBA_DRV RGB0PWM
busy  output  1  fade in progress
done  output  1  one-cycle pulse when a fade completes

Behaviour:
- Reset (rst=1 sampled on the clki edge) puts the block in this state:
  - state=IDLE; cfg_ready=1; busy=0; done=0
  - all pwm_* outputs = 0
  - PWM counter cnt = 0; prescaler = 0
  - cur_*, tgt_*, shadow_* = 0; latched div = 0
- Reset mid-fade aborts immediately. No done pulse is generated.
- PWM counter:
  - cnt increments every cycle and wraps from 2**PWM_BITS-1 to 0.
  - When cnt == 2**PWM_BITS-1, shadow_x <= cur_x. The new duty therefore applies from the next cnt==0.
- PWM outputs:
  - pwm_x is registered: pwm_x <= (cnt < shadow_x), i.e. one cycle of latency from cnt.
  - Duty 0 gives a constant 0.
  - Duty D gives exactly D high cycles per 2**PWM_BITS-cycle period, so the maximum duty is (2**PWM_BITS-1)/2**PWM_BITS.
- Handshake:
  - cfg_ready = (state==IDLE).
  - A request is accepted on any cycle with cfg_valid && cfg_ready. On acceptance, tgt_* <= cfg_*, div <= cfg_div, prescaler <= 0, state <= FADING.
  - cfg_* are ignored while cfg_ready=0. There is no queuing, and a request held on cfg_valid is accepted on the first cycle after done.
- FSM:
  - IDLE: waits for an accepted request; busy=0.
  - FADING: busy=1.
    - Prescaler counts 0..div. tick=1 on the cycle where prescaler==div; the prescaler then returns to 0.
    - div=0 gives a tick every cycle.
    - On each tick, each channel moves independently: cur_x <= cur_x+1 if cur_x<tgt_x, cur_x-1 if cur_x>tgt_x, otherwise unchanged.
    - No wrap-around: unsigned compare, and a channel never passes its target.
  - FADING -> IDLE: on the first cycle in FADING where all cur_x==tgt_x (checked before any step). On that transition, done is registered high for exactly one cycle, coincident with cfg_ready returning to 1.
- Fade timing:
  - A request whose targets equal the current values completes with done in the cycle after acceptance.
  - Fade duration in cycles = (div+1) * max_x |tgt_x - cur_x|, plus 1 cycle for the completion check.
- cur_x is never directly observable on a port; it reaches the outputs only through shadow_x.

Test Plan:
- Reset with PWM_BITS=8 -> all pwm_*=0, cfg_ready=1, busy=0, done=0 for 512 cycles.
- Request r=255,g=128,b=0 with div=0 from reset:
  - cfg_ready drops the cycle after acceptance; done pulses after 256 cycles, once max |Δ|=255 has been stepped.
  - Once settled, each 256-cycle period shows pwm_red high 255 cycles, pwm_green 128, pwm_blue 0.
- Fade down: from steady g=128, request g=0 with div=3 -> done after 4*128+1 cycles; measured green duty per period is non-increasing and ends at 0.
- Mid-period change: record the cnt value when cur_green changes. pwm_green's high-cycle count in that period equals the old shadow value; the new value appears only from the next cnt=0.
- Handshake: hold cfg_valid=1 with new targets during a fade -> not accepted until the cycle after done. No-op request (targets equal current) -> done 1 cycle after acceptance.
- Assert rst for one cycle mid-fade (cur_red=100, target 200) -> the next cycle shows state IDLE, cur=0, all pwm_*=0, and no done pulse.
